ifu_fetch: RTL and testbench

Instruction fetch unit for the single-cycle MIPS core. It holds the PC register and the instruction ROM, and computes the next PC from the controller's npc_op. It sits directly upstream of the control decoder: it supplies the instruction word whose op_code and funct drive control, and it consumes control's npc_op in the same cycle. A sticky fault state freezes fetch when the next PC would leave the instruction-memory window.

---
 rtl/cpu_defs_pkg.sv | 20 ++
 rtl/ifu_npc.sv | 53 +++++
 rtl/ifu_fetch.sv | 88 ++++++++
 tb/tb_ifu_fetch.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the single-cycle MIPS core: next-PC select codes
// (same encoding the control decoder drives), reset PC and the nop word.
package cpu_defs_pkg;

   localparam logic [2:0] NPC_PC4 = 3'b000;
   localparam logic [2:0] NPC_BEQ = 3'b001;
   localparam logic [2:0] NPC_JAL = 3'b010;
   localparam logic [2:0] NPC_JR  = 3'b011;

   localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

   // sll $0,$0,0 -- control asserts no writes for this word
   localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

   typedef enum logic {
      FETCH_RUN   = 1'b0,
      FETCH_FAULT = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/ifu_npc.sv
// Next-PC computation: PC+4, branch, jal and jr targets, plus the check that
// the chosen target lies inside the instruction-memory window. Purely
// combinational so the pipelined D stage can reuse it unchanged.
module ifu_npc
   import cpu_defs_pkg::*;
#(
   parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
   parameter int          IM_DEPTH = 4096
) (
   input  logic [31:0] pc,
   // Low 26 bits of the instruction word: the jal index field, whose low
   // half is also the 16-bit branch immediate. The opcode bits are not needed.
   input  logic [25:0] instr,
   input  logic [2:0]  npc_op,
   input  logic [31:0] rs_data,
   output logic [31:0] next_pc,
   output logic [31:0] pc_plus4,
   output logic        next_pc_valid
);

   // One past the last ROM byte, kept at 33 bits so a window ending at 2**32
   // does not wrap to zero.
   localparam logic [32:0] WINDOW_END = {1'b0, PC_RESET} + (33'(IM_DEPTH) * 33'd4);

   logic [31:0] branch_offset;
   logic [31:0] branch_target;
   logic [31:0] jal_target;

   assign pc_plus4      = pc + 32'd4;
   assign branch_offset = {{14{instr[15]}}, instr[15:0], 2'b00};
   assign branch_target = pc_plus4 + branch_offset;
   assign jal_target    = {pc_plus4[31:28], instr[25:0], 2'b00};

   // Select the next PC; reserved codes fall back to sequential fetch.
   always_comb begin
      next_pc = pc_plus4;
      case (npc_op)
         NPC_PC4: next_pc = pc_plus4;
         NPC_BEQ: next_pc = branch_target;
         NPC_JAL: next_pc = jal_target;
         NPC_JR:  next_pc = rs_data;
         default: next_pc = pc_plus4;
      endcase
   end

   // A target is fetchable only if word aligned and inside the ROM window.
   always_comb begin
      next_pc_valid = (next_pc[1:0] == 2'b00) &&
                      (next_pc >= PC_RESET) &&
                      ({1'b0, next_pc} < WINDOW_END);
   end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: PC register, asynchronous instruction ROM and a
// sticky fault state that freezes fetch once the next PC leaves the ROM.
module ifu_fetch
   import cpu_defs_pkg::*;
#(
   parameter logic [31:0] PC_RESET     = PC_RESET_DEFAULT,
   parameter int          IM_DEPTH     = 4096,
   parameter int          IM_ADDR_W    = 12,
   parameter              IM_INIT_FILE = "code.txt"
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  npc_op,
   input  logic [31:0] rs_data,
   output logic [31:0] instr,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        fault,
   output logic [31:0] fault_pc
);

   // PC_RESET is word aligned, so subtracting only the index bits gives the
   // same result as (pc - PC_RESET) >> 2 truncated to IM_ADDR_W bits.
   localparam logic [IM_ADDR_W-1:0] ROM_BASE_INDEX = PC_RESET[IM_ADDR_W+1:2];

   logic [31:0]          rom [0:IM_DEPTH-1];
   logic [IM_ADDR_W-1:0] rom_index;
   logic [31:0]          rom_word;
   logic [31:0]          next_pc;
   logic                 next_pc_valid;
   fetch_state_t         state;
   logic [31:0]          pc_q;
   logic [31:0]          fault_pc_q;

   assign rom_index = pc_q[IM_ADDR_W+1:2] - ROM_BASE_INDEX;
   assign rom_word  = rom[rom_index];

   // While faulted, feed a nop so downstream control performs no writes.
   always_comb begin
      instr = rom_word;
      if (state == FETCH_FAULT) begin
         instr = INSTR_NOP;
      end
   end

   ifu_npc #(
      .PC_RESET (PC_RESET),
      .IM_DEPTH (IM_DEPTH)
   ) u_npc (
      .pc            (pc_q),
      .instr         (instr[25:0]),
      .npc_op        (npc_op),
      .rs_data       (rs_data),
      .next_pc       (next_pc),
      .pc_plus4      (pc_plus4),
      .next_pc_valid (next_pc_valid)
   );

   // RUN advances the PC or, on an out-of-window target, records it and
   // freezes; only reset leaves FAULT.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= FETCH_RUN;
         pc_q       <= PC_RESET;
         fault_pc_q <= 32'h0;
      end else begin
         case (state)
            FETCH_RUN: begin
               if (next_pc_valid) begin
                  pc_q <= next_pc;
               end else begin
                  fault_pc_q <= next_pc;
                  state      <= FETCH_FAULT;
               end
            end
            FETCH_FAULT: begin
               state <= FETCH_FAULT;
            end
            default: state <= FETCH_FAULT;
         endcase
      end
   end

   assign pc       = pc_q;
   assign fault    = (state == FETCH_FAULT);
   assign fault_pc = fault_pc_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed scoreboard bench for ifu_fetch: each step drives inputs, queues
// the state expected after the next edge, then pops and compares it.
module tb_ifu_fetch;
   import cpu_defs_pkg::*;

   typedef struct {
      string       tag;
      logic [31:0] pc;
      logic        fault;
      logic [31:0] fault_pc;
   } exp_t;

   logic        clk;
   logic        reset;
   logic [2:0]  npc_op;
   logic [31:0] rs_data;
   logic [31:0] instr;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        fault;
   logic [31:0] fault_pc;

   logic [31:0] rom_model [0:4095];
   exp_t        sb [$];
   int          checks;
   int          failures;

   ifu_fetch #(
      .PC_RESET     (32'h0000_3000),
      .IM_DEPTH     (4096),
      .IM_ADDR_W    (12),
      .IM_INIT_FILE ("")
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .npc_op   (npc_op),
      .rs_data  (rs_data),
      .instr    (instr),
      .pc       (pc),
      .pc_plus4 (pc_plus4),
      .fault    (fault),
      .fault_pc (fault_pc)
   );

   // 10 ns free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic setRomWord(input int idx, input logic [31:0] word);
      rom_model[idx] = word;
      dut.rom[idx]   = word;
   endtask

   task automatic checkOutput();
      exp_t        e;
      logic [31:0] exp_instr;
      logic [31:0] offs;
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $error("[TB] FAIL scoreboard_empty: got 0 entries expected 1");
         return;
      end
      e    = sb.pop_front();
      offs = (e.pc - 32'h0000_3000) >> 2;
      exp_instr = e.fault ? INSTR_NOP : rom_model[offs[11:0]];
      check32({e.tag, ".pc"},       pc,              e.pc);
      check32({e.tag, ".fault"},    {31'h0, fault},  {31'h0, e.fault});
      check32({e.tag, ".fault_pc"}, fault_pc,        e.fault_pc);
      check32({e.tag, ".instr"},    instr,           exp_instr);
      check32({e.tag, ".pc_plus4"}, pc_plus4,        e.pc + 32'd4);
   endtask

   task automatic applyStimulus(input string tag, input logic rst, input logic [2:0] op,
                                input logic [31:0] rs, input logic [31:0] exp_pc,
                                input logic exp_fault, input logic [31:0] exp_fault_pc);
      exp_t e;
      reset   = rst;
      npc_op  = op;
      rs_data = rs;
      e.tag      = tag;
      e.pc       = exp_pc;
      e.fault    = exp_fault;
      e.fault_pc = exp_fault_pc;
      sb.push_back(e);
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      npc_op   = NPC_PC4;
      rs_data  = 32'h0;

      for (int i = 0; i < 4096; i++) begin
         setRomWord(i, 32'hA500_0000 | 32'(i));
      end
      setRomWord(2,    32'h1000_FFFD);
      setRomWord(3,    32'h0C00_0C10);
      setRomWord(5,    32'h1000_FFFF);
      setRomWord(4095, 32'hDEAD_0FFF);

      // reset then sequential fetch
      applyStimulus("rst0", 1'b1, NPC_PC4, 32'h0, 32'h3000, 1'b0, 32'h0);
      applyStimulus("rst1", 1'b1, NPC_PC4, 32'h0, 32'h3000, 1'b0, 32'h0);
      applyStimulus("seq1", 1'b0, NPC_PC4, 32'h0, 32'h3004, 1'b0, 32'h0);
      applyStimulus("seq2", 1'b0, NPC_PC4, 32'h0, 32'h3008, 1'b0, 32'h0);

      // backward and forward branches
      applyStimulus("beq_back", 1'b0, NPC_BEQ, 32'h0, 32'h3000, 1'b0, 32'h0);
      setRomWord(2, 32'h1000_0003);
      applyStimulus("seq3", 1'b0, NPC_PC4, 32'h0, 32'h3004, 1'b0, 32'h0);
      applyStimulus("seq4", 1'b0, NPC_PC4, 32'h0, 32'h3008, 1'b0, 32'h0);
      applyStimulus("beq_fwd", 1'b0, NPC_BEQ, 32'h0, 32'h3018, 1'b0, 32'h0);

      // jal then jr back to the link address
      applyStimulus("rst2", 1'b1, NPC_PC4, 32'h0, 32'h3000, 1'b0, 32'h0);
      applyStimulus("seq5", 1'b0, NPC_PC4, 32'h0, 32'h3004, 1'b0, 32'h0);
      applyStimulus("seq6", 1'b0, NPC_PC4, 32'h0, 32'h3008, 1'b0, 32'h0);
      applyStimulus("seq7", 1'b0, NPC_PC4, 32'h0, 32'h300C, 1'b0, 32'h0);
      npc_op = NPC_JAL;
      #1;
      check32("jal_link", pc_plus4, 32'h3010);
      applyStimulus("jal", 1'b0, NPC_JAL, 32'h0, 32'h3040, 1'b0, 32'h0);
      applyStimulus("jr",  1'b0, NPC_JR, 32'h3010, 32'h3010, 1'b0, 32'h0);

      // unaligned jr faults and stays frozen
      applyStimulus("jr_unaligned", 1'b0, NPC_JR, 32'h3002, 32'h3010, 1'b1, 32'h3002);
      for (int i = 0; i < 5; i++) begin
         applyStimulus("fault_hold", 1'b0, NPC_JAL, 32'h0, 32'h3010, 1'b1, 32'h3002);
      end

      // reset clears a fault even with a jump requested
      applyStimulus("rst_fault", 1'b1, NPC_JAL, 32'h0, 32'h3000, 1'b0, 32'h0);

      // branch to itself loops
      for (int i = 1; i <= 5; i++) begin
         applyStimulus("seq_self", 1'b0, NPC_PC4, 32'h0, 32'h3000 + 32'(4 * i), 1'b0, 32'h0);
      end
      applyStimulus("beq_self0", 1'b0, NPC_BEQ, 32'h0, 32'h3014, 1'b0, 32'h0);
      applyStimulus("beq_self1", 1'b0, NPC_BEQ, 32'h0, 32'h3014, 1'b0, 32'h0);

      // walk to the last ROM word, then step off the end
      applyStimulus("rst3", 1'b1, NPC_PC4, 32'h0, 32'h3000, 1'b0, 32'h0);
      for (int i = 1; i <= 4095; i++) begin
         applyStimulus("walk", 1'b0, NPC_PC4, 32'h0, 32'h3000 + 32'(4 * i), 1'b0, 32'h0);
      end
      applyStimulus("past_end", 1'b0, NPC_PC4, 32'h0, 32'h6FFC, 1'b1, 32'h7000);

      // jr below the window faults
      applyStimulus("rst4", 1'b1, NPC_PC4, 32'h0, 32'h3000, 1'b0, 32'h0);
      applyStimulus("jr_below", 1'b0, NPC_JR, 32'h2FFC, 32'h3000, 1'b1, 32'h2FFC);

      // reset mid-run wins over jal
      applyStimulus("rst5", 1'b1, NPC_PC4, 32'h0, 32'h3000, 1'b0, 32'h0);
      applyStimulus("seq8", 1'b0, NPC_PC4, 32'h0, 32'h3004, 1'b0, 32'h0);
      applyStimulus("rst_over_jal", 1'b1, NPC_JAL, 32'h0, 32'h3000, 1'b0, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
